// File: rtl/render_pkg.sv
// Shared types for the render front end: vertex fetch sequencing and triangle layout.
package render_pkg;

  localparam int VERT_WORDS    = 4;
  localparam int WORDS_PER_TRI = 3 * VERT_WORDS;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    PRESENT,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [VERT_WORDS-1:0][31:0] w;
  } vertex_t;

  typedef vertex_t [2:0] tri_t;

endpackage

// File: rtl/vertex_fetch_ctrl.sv
// Walks the vertex buffer one Avalon word at a time, assembles triangles and hands
// them downstream, then waits for the pipeline to drain before pulsing done.
module vertex_fetch_ctrl
  import render_pkg::*;
#(
  parameter int ADDR_W         = 26,
  parameter int WORDS_PER_VERT = VERT_WORDS,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             vertex_buffer_base,
  input  logic [CNT_W-1:0]              tri_count,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_read,
  input  logic                          avm_waitrequest,
  input  logic [31:0]                   avm_readdata,
  input  logic                          avm_readdatavalid,
  output logic                          tri_valid,
  input  logic                          tri_ready,
  output logic [96*WORDS_PER_VERT-1:0]  tri_data,
  output logic                          tri_last,
  input  logic                          pipe_idle,
  output logic                          busy,
  output logic                          done
);

  localparam int TRI_WORDS = 3 * WORDS_PER_VERT;
  localparam int SLOT_W    = $clog2(TRI_WORDS);
  localparam int WIDX_W    = CNT_W + 4;

  // Handshakes: a read command completes on a cycle with avm_read && !avm_waitrequest,
  // and a triangle transfers on a cycle with tri_valid && tri_ready; the command and
  // the triangle payload stay frozen until their completing cycle.

  fetch_state_t            state, state_nxt;
  logic [ADDR_W-1:0]       base_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        tri_idx;
  logic [WIDX_W-1:0]       word_idx;
  logic [SLOT_W-1:0]       slot;
  logic [31:0]             tri_buf [TRI_WORDS];
  logic                    last_slot;
  logic                    last_tri;

  // slot tracks word_idx mod TRI_WORDS without a divider
  assign last_slot = (slot == SLOT_W'(TRI_WORDS - 1));
  assign last_tri  = (tri_idx == count_q - CNT_W'(1));

  assign avm_read    = (state == ISSUE);
  assign avm_address = avm_read ? base_q + ADDR_W'({word_idx, 2'b00}) : '0;
  assign tri_valid   = (state == PRESENT);
  assign tri_last    = tri_valid && last_tri;

  always_comb begin
    tri_data = '0;
    for (int i = 0; i < TRI_WORDS; i++) tri_data[32*i +: 32] = tri_buf[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = (tri_count == '0) ? DONE : ISSUE;
      ISSUE:     if (!avm_waitrequest) state_nxt = WAIT_DATA;
      WAIT_DATA: if (avm_readdatavalid) state_nxt = last_slot ? PRESENT : ISSUE;
      PRESENT:   if (tri_ready) state_nxt = last_tri ? DRAIN : ISSUE;
      DRAIN:     if (pipe_idle) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      tri_idx  <= '0;
      word_idx <= '0;
      slot     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < TRI_WORDS; i++) tri_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      // done lags the DONE state by one edge, and busy falls on that same edge
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= vertex_buffer_base;
            count_q  <= tri_count;
            tri_idx  <= '0;
            word_idx <= '0;
            slot     <= '0;
            busy     <= 1'b1;
          end
        end
        WAIT_DATA: begin
          if (avm_readdatavalid) begin
            tri_buf[slot] <= avm_readdata;
            word_idx      <= word_idx + WIDX_W'(1);
            slot          <= last_slot ? '0 : slot + SLOT_W'(1);
          end
        end
        PRESENT: begin
          if (tri_ready) tri_idx <= tri_idx + CNT_W'(1);
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vertex_fetch_ctrl.md
Name: vertex_fetch_ctrl

Overview:
- Sequences one render pass after the host writes start_render into the configuration register block.
- Walks the vertex buffer in DDR/SDRAM through an Avalon-MM read master, one word per read.
- Assembles each triangle (3 vertices × WORDS_PER_VERT words) and hands it to the transform stage with a valid/ready handshake.
- Waits for the pipeline to drain, then pulses done, which feeds done_in of the config block.

Parameters:
- ADDR_W, 26, Avalon byte-address width; matches vertex_buffer_base.
- WORDS_PER_VERT, 4, 32-bit words per vertex (x, y, z, attribute).
- CNT_W, 16, width of the triangle count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle start pulse (from start_render)
- vertex_buffer_base  in  ADDR_W  byte base address of the vertex array
- tri_count  in  CNT_W  number of triangles to fetch; sampled on start
- avm_address  out  ADDR_W  read byte address
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid
- tri_valid  out  1  triangle available downstream
- tri_ready  in  1  downstream accepts triangle
- tri_data  out  96*WORDS_PER_VERT  flattened triangle; word 0 in bits [31:0], ascending
- tri_last  out  1  qualifies the final triangle of the pass
- pipe_idle  in  1  downstream pipeline empty
- busy  out  1  high from the start edge until done
- done  out  1  one-cycle pulse when the pass completes

Behaviour:
- Reset: synchronous, active-high, on the clk edge.
  - State returns to IDLE.
  - avm_read, avm_address, tri_valid, tri_last, busy, done and tri_data are all cleared to 0.
  - Reset mid-pass abandons the pass: avm_read is low from the next edge, and no done is issued.
- States: IDLE, ISSUE, WAIT_DATA, PRESENT, DRAIN, DONE.
- IDLE:
  - On start, latch base and tri_count, clear word and triangle counters, set busy.
  - If tri_count == 0, go to DONE. Otherwise go to ISSUE.
  - start is ignored in every other state.
- ISSUE:
  - avm_read = 1.
  - avm_address = base + 4*word_idx, computed modulo 2^ADDR_W; the address wraps silently.
  - avm_address and avm_read are held stable while avm_waitrequest = 1.
  - The cycle with avm_waitrequest = 0 completes the command; next state is WAIT_DATA, and avm_read drops.
  - Exactly one read is outstanding at any time.
- WAIT_DATA:
  - On avm_readdatavalid, store avm_readdata into slot word_idx mod (3*WORDS_PER_VERT) and increment word_idx.
  - If that slot was the last of the triangle, go to PRESENT. Otherwise go to ISSUE.
  - avm_readdatavalid outside WAIT_DATA is ignored.
- PRESENT:
  - tri_valid = 1, with tri_data and tri_last held stable until tri_ready.
  - tri_last = 1 when tri_idx == tri_count - 1.
  - On the handshake cycle: increment tri_idx and drop tri_valid on the next edge.
  - After the handshake, go to DRAIN if that was the last triangle, else ISSUE.
  - No new read is issued until the handshake completes; this gives one-triangle buffering.
- DRAIN: wait for pipe_idle = 1, then go to DONE. pipe_idle is sampled only in this state.
- DONE: done = 1 for exactly one cycle, busy clears on the same edge, next state IDLE. A new start is accepted from the following cycle.
- Widths:
  - word_idx is CNT_W + 4 bits wide. It never overflows for tri_count ≤ 2^CNT_W - 1.
  - tri_idx is CNT_W bits wide.
- Throughput: minimum 2 cycles per word. A triangle costs at least 2*3*WORDS_PER_VERT + 1 cycles.

Decomposition:
- render_pkg (shared package) holds:
  - the fetch_state_t enum;
  - the constant WORDS_PER_TRI = 3*WORDS_PER_VERT;
  - vertex_t: a packed struct of WORDS_PER_VERT × 32-bit words;
  - tri_t: vertex_t [2:0].
- No sub-module. The triangle assembly register stays inline; it is a single register array.

Test Plan:
- Triangle order and addressing: tri_count = 2, base = 0x300000, zero-wait slave returning address as data. Expect:
  - 24 reads at 0x300000 to 0x30005C in steps of 4;
  - two triangles, the first with word0 = 0x300000, the second with word0 = 0x300030;
  - tri_last only on the second;
  - done one cycle after pipe_idle.
- Stall holding: avm_waitrequest held high 5 cycles on read 3. Expect avm_address = 0x30000C and avm_read stable across all 5 cycles, no extra read, correct data placed.
- Empty pass: tri_count = 0 with start. Expect:
  - no avm_read;
  - done two cycles after start, i.e. the start edge moves IDLE to DONE and done rises on the next edge;
  - busy high for exactly that interval.
- Back-pressure: tri_ready low for 10 cycles with pipe_idle = 0 for 4 cycles after the last handshake. Expect:
  - tri_data stable throughout the stall;
  - no reads during PRESENT;
  - done only after pipe_idle rises;
  - a second start during busy is ignored.
- Address wrap: base = 0x3FFFFF8, tri_count = 1. Expect addresses 0x3FFFFF8, 0x3FFFFFC, 0x0000000, … 0x0000024.
- Mid-pass reset: assert reset during WAIT_DATA of triangle 1. Expect:
  - all outputs 0 at the next edge;
  - no done pulse;
  - after release, a fresh start fetches from word 0.
